// File: rtl/rv_debug_pkg.sv
// Shared definitions for the register-file debug readback logic.
package rv_debug_pkg;

  // Dump sequencer states.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETTLE = 3'd1,
    LOAD   = 3'd2,
    SEND   = 3'd3,
    FINISH = 3'd4
  } dump_state_t;

  // Default register count (x0..x31) and register index width.
  localparam int NREGS_DEFAULT = 32;
  localparam int REG_AW        = 5;

endpackage

// File: rtl/reg_dump_unit.sv
// Register-file dump engine: stalls the core, walks x0..x(NREGS-1) through a
// spare read port and streams each value over a valid/ready handshake.
module reg_dump_unit
  import rv_debug_pkg::*;
#(
  parameter int width = 32,
  parameter int NREGS = NREGS_DEFAULT,
  parameter int AW    = REG_AW
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             start,
  input  logic             abort,
  output logic [AW-1:0]    RA,
  input  logic [width-1:0] RD,
  output logic             halt_req,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [width-1:0] out_data,
  output logic [AW-1:0]    out_index,
  output logic             out_last,
  output logic             busy,
  output logic             done
);

  localparam logic [AW-1:0] LAST_IDX = AW'(NREGS - 1);

  dump_state_t      state_q, state_d;
  logic [AW-1:0]    idx_q, idx_d;
  logic             halt_q, halt_d;
  logic             valid_q, valid_d;
  logic [width-1:0] data_q, data_d;
  logic [AW-1:0]    index_q, index_d;
  logic             last_q, last_d;
  logic             done_q, done_d;

  // State register.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; abort returns to IDLE from any active state and also
  // blocks a simultaneous start while idle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start && !abort) state_d = SETTLE;
        else                 state_d = IDLE;
      end
      SETTLE: begin
        if (abort) state_d = IDLE;
        else       state_d = LOAD;
      end
      LOAD: begin
        if (abort) state_d = IDLE;
        else       state_d = SEND;
      end
      SEND: begin
        if (abort)          state_d = IDLE;
        else if (out_ready) state_d = last_q ? FINISH : LOAD;
        else                state_d = SEND;
      end
      FINISH: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Datapath next values: index counter, halt request and the output beat.
  always_comb begin
    idx_d   = idx_q;
    halt_d  = halt_q;
    valid_d = valid_q;
    data_d  = data_q;
    index_d = index_q;
    last_d  = last_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && !abort) begin
          idx_d  = '0;
          halt_d = 1'b1;
        end else begin
          halt_d = 1'b0;
        end
      end
      SETTLE, LOAD, SEND: begin
        if (abort) begin
          idx_d   = '0;
          halt_d  = 1'b0;
          valid_d = 1'b0;
          last_d  = 1'b0;
        end else if (state_q == LOAD) begin
          // x0 is hardwired zero whatever the read port returns.
          data_d  = (idx_q == '0) ? '0 : RD;
          index_d = idx_q;
          last_d  = (idx_q == LAST_IDX);
          valid_d = 1'b1;
        end else if (state_q == SEND && out_ready) begin
          valid_d = 1'b0;
          if (last_q) done_d = 1'b1;
          else        idx_d  = idx_q + AW'(1);
        end else begin
          valid_d = valid_q;
        end
      end
      FINISH: begin
        halt_d = 1'b0;
      end
      default: begin
        idx_d   = '0;
        halt_d  = 1'b0;
        valid_d = 1'b0;
        last_d  = 1'b0;
      end
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      idx_q   <= '0;
      halt_q  <= 1'b0;
      valid_q <= 1'b0;
      data_q  <= '0;
      index_q <= '0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      idx_q   <= idx_d;
      halt_q  <= halt_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      index_q <= index_d;
      last_q  <= last_d;
      done_q  <= done_d;
    end
  end

  assign RA        = idx_q;
  assign halt_req  = halt_q;
  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign out_index = index_q;
  assign out_last  = last_q;
  assign done      = done_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_reg_dump_unit.sv
// Directed bench for reg_dump_unit: default 32-register build plus a
// 4-register build sharing the clock and reset.
module tb_reg_dump_unit;

  logic        CLK = 1'b0;
  logic        RST;

  logic        start_a, abort_a, ready_a;
  logic [4:0]  ra_a, index_a;
  logic [31:0] rd_a, data_a;
  logic        halt_a, valid_a, last_a, busy_a, done_a;

  logic        start_b, abort_b, ready_b;
  logic [4:0]  ra_b, index_b;
  logic [31:0] rd_b, data_b;
  logic        halt_b, valid_b, last_b, busy_b, done_b;

  int n_checks = 0;
  int n_errors = 0;

  always #5 CLK = ~CLK;

  // Register-file model: x0 holds garbage to prove it is masked.
  assign rd_a = (ra_a == 5'd0) ? 32'hDEAD_BEEF : 32'h1000_0000 + {27'd0, ra_a};
  assign rd_b = (ra_b == 5'd0) ? 32'hDEAD_BEEF : 32'h1000_0000 + {27'd0, ra_b};

  reg_dump_unit dut_a (
    .CLK(CLK), .RST(RST), .start(start_a), .abort(abort_a),
    .RA(ra_a), .RD(rd_a), .halt_req(halt_a), .out_valid(valid_a),
    .out_ready(ready_a), .out_data(data_a), .out_index(index_a),
    .out_last(last_a), .busy(busy_a), .done(done_a)
  );

  reg_dump_unit #(.width(32), .NREGS(4), .AW(5)) dut_b (
    .CLK(CLK), .RST(RST), .start(start_b), .abort(abort_b),
    .RA(ra_b), .RD(rd_b), .halt_req(halt_b), .out_valid(valid_b),
    .out_ready(ready_b), .out_data(data_b), .out_index(index_b),
    .out_last(last_b), .busy(busy_b), .done(done_b)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_data(input int i);
    return (i == 0) ? 32'd0 : 32'h1000_0000 + 32'(i);
  endfunction

  // Full dump on instance A; optional 10-cycle stall at stall_idx and a
  // stray start pulse during beat restart_idx (-1 disables each).
  task automatic dump_a(input int stall_idx, input int restart_idx);
    int  exp_idx, n, stall_cnt, exp_done_edge;
    bit  restarted, finished;
    exp_done_edge = 65 + ((stall_idx >= 0) ? 10 : 0);
    exp_idx = 0; n = 0; stall_cnt = 0; restarted = 0; finished = 0;
    @(negedge CLK); ready_a = 1'b1; start_a = 1'b1;
    @(negedge CLK); start_a = 1'b0;
    check_val("busy_after_start", 32'(busy_a), 32'd1);
    check_val("halt_after_start", 32'(halt_a), 32'd1);
    while (!finished && n < 300) begin
      @(negedge CLK); n++;
      start_a = 1'b0;
      if (done_a) begin
        check_val("done_edge", 32'(n), 32'(exp_done_edge));
        check_val("beats_total", 32'(exp_idx), 32'd32);
        finished = 1'b1;
      end else begin
        check_val("halt_held", 32'(halt_a), 32'd1);
      end
      if (valid_a) begin
        check_val("beat_index", 32'(index_a), 32'(exp_idx));
        check_val("beat_data", data_a, exp_data(exp_idx));
        check_val("beat_last", 32'(last_a), (exp_idx == 31) ? 32'd1 : 32'd0);
        if (exp_idx == stall_idx && stall_cnt < 10) begin
          ready_a = 1'b0; stall_cnt++;
        end else begin
          ready_a = 1'b1;
          if (exp_idx == restart_idx && !restarted) begin
            start_a = 1'b1; restarted = 1'b1;
          end
          exp_idx++;
        end
      end
    end
    check_val("dump_completed", 32'(finished), 32'd1);
    for (int k = 0; k < 3; k++) begin
      @(negedge CLK);
      check_val("post_done", 32'(done_a), 32'd0);
      check_val("post_halt", 32'(halt_a), 32'd0);
      check_val("post_busy", 32'(busy_a), 32'd0);
    end
  endtask

  // Start a dump on A and return at the negedge where beat 'target' is shown.
  task automatic run_to_a(input int target);
    bit found;
    found = 1'b0;
    @(negedge CLK); ready_a = 1'b1; start_a = 1'b1;
    @(negedge CLK); start_a = 1'b0;
    for (int k = 0; k < 200 && !found; k++) begin
      if (valid_a && index_a == 5'(target)) found = 1'b1;
      else @(negedge CLK);
    end
    check_val("reach_index", 32'(found), 32'd1);
  endtask

  // Full dump on the 4-register instance.
  task automatic dump_b();
    int exp_idx, n;
    bit finished;
    exp_idx = 0; n = 0; finished = 0;
    @(negedge CLK); ready_b = 1'b1; start_b = 1'b1;
    @(negedge CLK); start_b = 1'b0;
    while (!finished && n < 100) begin
      @(negedge CLK); n++;
      if (done_b) begin
        check_val("b_done_edge", 32'(n), 32'd9);
        check_val("b_beats_total", 32'(exp_idx), 32'd4);
        finished = 1'b1;
      end
      if (valid_b) begin
        check_val("b_beat_index", 32'(index_b), 32'(exp_idx));
        check_val("b_beat_data", data_b, exp_data(exp_idx));
        check_val("b_beat_last", 32'(last_b), (exp_idx == 3) ? 32'd1 : 32'd0);
        exp_idx++;
      end
    end
    check_val("b_dump_completed", 32'(finished), 32'd1);
    @(negedge CLK);
    check_val("b_post_busy", 32'(busy_b), 32'd0);
  endtask

  initial begin
    RST = 1'b0;
    start_a = 1'b0; abort_a = 1'b0; ready_a = 1'b0;
    start_b = 1'b0; abort_b = 1'b0; ready_b = 1'b0;
    #12;
    check_val("rst_ra", 32'(ra_a), 32'd0);
    check_val("rst_halt", 32'(halt_a), 32'd0);
    check_val("rst_valid", 32'(valid_a), 32'd0);
    check_val("rst_data", data_a, 32'd0);
    check_val("rst_busy", 32'(busy_a), 32'd0);
    check_val("rst_done", 32'(done_a), 32'd0);
    @(negedge CLK); RST = 1'b1;

    // start and abort together while idle: stays idle.
    @(negedge CLK); start_a = 1'b1; abort_a = 1'b1;
    @(negedge CLK); start_a = 1'b0; abort_a = 1'b0;
    check_val("idle_abort_busy", 32'(busy_a), 32'd0);
    check_val("idle_abort_halt", 32'(halt_a), 32'd0);

    // Plain dump, then stall at beat 7 and a stray start at beat 12.
    dump_a(-1, -1);
    dump_a(7, 12);

    // Abort in SEND at beat 20 with out_ready high in the same cycle.
    run_to_a(20);
    abort_a = 1'b1; ready_a = 1'b1;
    @(negedge CLK); abort_a = 1'b0;
    check_val("abort_valid", 32'(valid_a), 32'd0);
    check_val("abort_halt", 32'(halt_a), 32'd0);
    check_val("abort_busy", 32'(busy_a), 32'd0);
    check_val("abort_done", 32'(done_a), 32'd0);
    check_val("abort_ra", 32'(ra_a), 32'd0);
    for (int k = 0; k < 3; k++) begin
      @(negedge CLK);
      check_val("abort_no_done", 32'(done_a), 32'd0);
    end
    dump_a(-1, -1);

    // Asynchronous reset mid-dump at beat 9.
    run_to_a(9);
    #2 RST = 1'b0;
    #1;
    check_val("arst_ra", 32'(ra_a), 32'd0);
    check_val("arst_halt", 32'(halt_a), 32'd0);
    check_val("arst_valid", 32'(valid_a), 32'd0);
    check_val("arst_data", data_a, 32'd0);
    check_val("arst_index", 32'(index_a), 32'd0);
    check_val("arst_last", 32'(last_a), 32'd0);
    check_val("arst_busy", 32'(busy_a), 32'd0);
    @(negedge CLK); RST = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge CLK);
      check_val("post_rst_busy", 32'(busy_a), 32'd0);
      check_val("post_rst_valid", 32'(valid_a), 32'd0);
      check_val("post_rst_halt", 32'(halt_a), 32'd0);
    end

    // Four-register build.
    dump_b();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
